// File: rtl/jk_drive_pkg.sv
// Shared types and JK excitation codes for the jk_drive_seq sequencer.
// Excitation codes are packed as {J, K}.
package jk_drive_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_e;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Inverse JK table: which {J,K} moves one cell from m to t. Toggle is never chosen.
    function automatic logic [1:0] jk_code(input logic m, input logic t);
        logic [1:0] code;
        code = JK_HOLD;
        if (!m && t) begin
            code = JK_SET;
        end else if (m && !t) begin
            code = JK_RESET;
        end
        return code;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational map from (current bank state, target word) to per-bit J/K vectors.
module jk_excite
    import jk_drive_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] model_i,
    input  logic [WIDTH-1:0] target_i,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o
);

    logic [1:0] code;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        j_o  = '0;
        k_o  = '0;
        code = JK_HOLD;
        for (int b = 0; b < WIDTH; b++) begin
            code   = jk_code(model_i[b], target_i[b]);
            j_o[b] = code[1];
            k_o[b] = code[0];
        end
    end

endmodule

// File: rtl/jk_drive_seq.sv
// Target-word sequencer for a JK register bank: drive excitation once, settle, then report done.
// Optional readback of the bank outputs is enabled with `define JK_DRIVE_SEQ_READBACK_EN.
module jk_drive_seq
    import jk_drive_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] model
);

    localparam int              CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] model_q, model_d;
    logic [WIDTH-1:0] exc_j, exc_k;

`ifndef JK_DRIVE_SEQ_READBACK_EN
    logic unused_q_fb;
    assign unused_q_fb = ^q_fb;
`endif

    jk_excite #(
        .WIDTH(WIDTH)
    ) u_excite (
        .model_i (model_q),
        .target_i(tgt_data),
        .j_o     (exc_j),
        .k_o     (exc_k)
    );

    assign tgt_ready = (state_q == IDLE);
    assign j         = j_q;
    assign k         = k_q;
    assign done      = done_q;
    assign err       = err_q;
    assign model     = model_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        j_d      = '0;
        k_d      = '0;
        done_d   = 1'b0;
        err_d    = err_q;
        model_d  = model_q;

        unique case (state_q)
            IDLE: begin
`ifdef JK_DRIVE_SEQ_READBACK_EN
                model_d = q_fb;
`endif
                if (tgt_valid) begin
                    state_d  = DRIVE;
                    target_d = tgt_data;
                    j_d      = exc_j;
                    k_d      = exc_k;
                    err_d    = 1'b0;
                end
            end
            DRIVE: begin
                state_d = SETTLE;
                cnt_d   = CNT_LOAD;
            end
            SETTLE: begin
                // Status is registered on entry to CHECK so err and model line up with done.
                if (cnt_q == CNT_ONE) begin
                    state_d = CHECK;
                    done_d  = 1'b1;
`ifdef JK_DRIVE_SEQ_READBACK_EN
                    err_d   = (q_fb != target_q);
                    model_d = q_fb;
`else
                    model_d = target_q;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            model_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            done_q  <= done_d;
            err_q   <= err_d;
            model_q <= model_d;
        end
    end

    // NOTE: target_q is pure datapath, only read after an accept has loaded it, so it carries no reset.
    always_ff @(posedge clk) begin
        target_q <= target_d;
    end

endmodule
